// File: rtl/rc4_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : rc4_pkg                                                   |
// | Description : State encoding and sizing helpers for rc4_stream.         |
// | Revision    : 1.0 - initial parametrised release                        |
// +------------------------------------------------------------------------+
package rc4_pkg;

  typedef logic [3:0] rc4_state_t;

  localparam rc4_state_t ST_IDLE    = 4'd0;
  localparam rc4_state_t ST_LOAD    = 4'd1;
  localparam rc4_state_t ST_INIT    = 4'd2;
  localparam rc4_state_t ST_KSA_J   = 4'd3;
  localparam rc4_state_t ST_KSA_SW  = 4'd4;
  localparam rc4_state_t ST_DROP    = 4'd5;
  localparam rc4_state_t ST_PRGA_J  = 4'd6;
  localparam rc4_state_t ST_PRGA_SW = 4'd7;
  localparam rc4_state_t ST_HOLD    = 4'd8;

  function automatic int sbox_size(input int word_w);
    return 1 << word_w;
  endfunction

  // Cycles from the key_last handshake to the first ks_valid.
  function automatic int first_ks_latency(input int word_w, input int drop_n);
    return 3 * sbox_size(word_w) + 2 + 2 * drop_n;
  endfunction

  localparam int LATENCY_W8 = first_ks_latency(8, 0);

endpackage
`default_nettype wire

// File: rtl/rc4_sbox.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : rc4_sbox                                                  |
// | Description : RC4 S-box flop array: init write, swap, 3 comb reads.     |
// | Revision    : 1.0 - initial parametrised release                        |
// +------------------------------------------------------------------------+
module rc4_sbox
  import rc4_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [WORD_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              swap_en,
  input  logic [WORD_W-1:0] swap_a,
  input  logic [WORD_W-1:0] swap_b,
  input  logic [WORD_W-1:0] rd_a_addr,
  output logic [WORD_W-1:0] rd_a_data,
  input  logic [WORD_W-1:0] rd_b_addr,
  output logic [WORD_W-1:0] rd_b_data,
  input  logic [WORD_W-1:0] rd_t_addr,
  output logic [WORD_W-1:0] rd_t_data
);

  localparam int DEPTH = sbox_size(WORD_W);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
    if (swap_en) begin
      mem_d[swap_a] = mem_q[swap_b];
      mem_d[swap_b] = mem_q[swap_a];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_a_data = mem_q[rd_a_addr];
  assign rd_b_data = mem_q[rd_b_addr];
  assign rd_t_data = mem_q[rd_t_addr];

endmodule
`default_nettype wire

// File: rtl/rc4_stream.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : rc4_stream                                                |
// | Description : RC4 keystream generator, streamed key, valid/ready out.   |
// |               Optional RC4-dropN via macro RC4_DROP_EN.                 |
// | Revision    : 1.0 - initial parametrised release                        |
// +------------------------------------------------------------------------+
module rc4_stream
  import rc4_pkg::*;
#(
  parameter int WORD_W  = 8,
  parameter int KEY_MAX = 16,
  parameter int DROP_N  = 768
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              abort,
  input  logic              key_valid,
  input  logic [WORD_W-1:0] key_data,
  input  logic              key_last,
  output logic              key_ready,
  output logic              ks_valid,
  output logic [WORD_W-1:0] ks_data,
  input  logic              ks_ready,
  output logic              busy,
  output logic              key_err
);

  localparam int CNT_W  = $clog2(KEY_MAX + 1);
  localparam int KIDX_W = (KEY_MAX > 1) ? $clog2(KEY_MAX) : 1;
  localparam logic [CNT_W-1:0]  C_KEY_MAX = CNT_W'(KEY_MAX);
  localparam logic [CNT_W-1:0]  C_CNT_ONE = CNT_W'(1);
  localparam logic [WORD_W-1:0] C_W_ONE   = WORD_W'(1);

  rc4_state_t        state_q, state_d;
  logic [WORD_W-1:0] i_q, i_d, j_q, j_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, key_len_q, key_len_d, kidx_q, kidx_d;
  logic [WORD_W-1:0] key_q [KEY_MAX];
  logic [WORD_W-1:0] key_d [KEY_MAX];
  logic              key_err_q, key_err_d;
  logic              ks_valid_q, ks_valid_d;
  logic [WORD_W-1:0] ks_data_q, ks_data_d;

  logic [WORD_W-1:0] w_rd_a_addr, w_rd_a, w_rd_b, w_rd_t, w_t_addr, w_ks_word;
  logic [WORD_W-1:0] w_key_word;
  logic [CNT_W-1:0]  w_cnt_base;
  logic              w_swap_en, w_drop_j, w_drop_sw, w_drop_last;
  rc4_state_t        w_after_ksa;

`ifdef RC4_DROP_EN
  localparam int DROP_W = (DROP_N > 0) ? $clog2(DROP_N + 1) : 1;

  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic              drop_ph_q, drop_ph_d;

  assign w_drop_j    = (state_q == ST_DROP) && !drop_ph_q;
  assign w_drop_sw   = (state_q == ST_DROP) && drop_ph_q;
  assign w_drop_last = (drop_cnt_q == DROP_W'(DROP_N - 1));
  assign w_after_ksa = (DROP_N > 0) ? ST_DROP : ST_PRGA_J;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    drop_ph_d  = drop_ph_q;
    if (abort) begin
      drop_cnt_d = '0;
      drop_ph_d  = 1'b0;
    end else if (w_drop_j) begin
      drop_ph_d = 1'b1;
    end else if (w_drop_sw) begin
      drop_ph_d  = 1'b0;
      drop_cnt_d = w_drop_last ? '0 : drop_cnt_q + DROP_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= '0;
      drop_ph_q  <= 1'b0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      drop_ph_q  <= drop_ph_d;
    end
  end
`else
  logic w_unused_drop;

  assign w_unused_drop = ^DROP_N;
  assign w_drop_j      = 1'b0;
  assign w_drop_sw     = 1'b0;
  assign w_drop_last   = 1'b0;
  assign w_after_ksa   = ST_PRGA_J;
`endif

  assign w_cnt_base  = (state_q == ST_IDLE) ? '0 : cnt_q;
  assign w_key_word  = key_q[kidx_q[KIDX_W-1:0]];
  assign w_rd_a_addr = ((state_q == ST_PRGA_J) || w_drop_j) ? i_q + C_W_ONE : i_q;
  assign w_swap_en   = (state_q == ST_KSA_SW) || (state_q == ST_PRGA_SW) || w_drop_sw;
  assign w_t_addr    = w_rd_a + w_rd_b;
  // Output reads the post-swap array; bypass when t hits one of the swapped slots.
  assign w_ks_word   = (w_t_addr == i_q) ? w_rd_b :
                       (w_t_addr == j_q) ? w_rd_a : w_rd_t;

  rc4_sbox #(.WORD_W(WORD_W)) u_sbox (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (state_q == ST_INIT),
    .wr_addr   (i_q),
    .wr_data   (i_q),
    .swap_en   (w_swap_en),
    .swap_a    (i_q),
    .swap_b    (j_q),
    .rd_a_addr (w_rd_a_addr),
    .rd_a_data (w_rd_a),
    .rd_b_addr (j_q),
    .rd_b_data (w_rd_b),
    .rd_t_addr (w_t_addr),
    .rd_t_data (w_rd_t)
  );

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    cnt_d      = cnt_q;
    key_len_d  = key_len_q;
    kidx_d     = kidx_q;
    key_d      = key_q;
    key_err_d  = key_err_q;
    ks_valid_d = ks_valid_q;
    ks_data_d  = ks_data_q;
    if (abort) begin
      state_d    = ST_IDLE;
      ks_valid_d = 1'b0;
      i_d        = '0;
      j_d        = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_LOAD: begin
          if (key_valid) begin
            if (state_q == ST_IDLE) begin
              key_err_d = 1'b0;
            end
            if (w_cnt_base < C_KEY_MAX) begin
              key_d[w_cnt_base[KIDX_W-1:0]] = key_data;
              cnt_d = w_cnt_base + C_CNT_ONE;
            end else begin
              key_err_d = 1'b1;
              cnt_d     = w_cnt_base;
            end
            if (key_last) begin
              key_len_d = (w_cnt_base >= C_KEY_MAX) ? C_KEY_MAX : w_cnt_base + C_CNT_ONE;
              kidx_d    = '0;
              i_d       = '0;
              state_d   = ST_INIT;
            end else begin
              state_d = ST_LOAD;
            end
          end
        end
        ST_INIT: begin
          i_d = i_q + C_W_ONE;
          if (i_q == '1) begin
            j_d     = '0;
            kidx_d  = '0;
            state_d = ST_KSA_J;
          end
        end
        ST_KSA_J: begin
          j_d     = j_q + w_rd_a + w_key_word;
          state_d = ST_KSA_SW;
        end
        ST_KSA_SW: begin
          i_d     = i_q + C_W_ONE;
          kidx_d  = (kidx_q + C_CNT_ONE == key_len_q) ? '0 : kidx_q + C_CNT_ONE;
          state_d = ST_KSA_J;
          if (i_q == '1) begin
            j_d     = '0;
            state_d = w_after_ksa;
          end
        end
        ST_DROP: begin
          if (w_drop_j) begin
            i_d = i_q + C_W_ONE;
            j_d = j_q + w_rd_a;
          end else if (w_drop_last) begin
            state_d = ST_PRGA_J;
          end
        end
        ST_PRGA_J: begin
          i_d     = i_q + C_W_ONE;
          j_d     = j_q + w_rd_a;
          state_d = ST_PRGA_SW;
        end
        ST_PRGA_SW: begin
          ks_data_d  = w_ks_word;
          ks_valid_d = 1'b1;
          state_d    = ST_HOLD;
        end
        ST_HOLD: begin
          if (ks_ready) begin
            ks_valid_d = 1'b0;
            state_d    = ST_PRGA_J;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      i_q        <= '0;
      j_q        <= '0;
      cnt_q      <= '0;
      key_len_q  <= '0;
      kidx_q     <= '0;
      key_err_q  <= 1'b0;
      ks_valid_q <= 1'b0;
      ks_data_q  <= '0;
      for (int k = 0; k < KEY_MAX; k++) begin
        key_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      cnt_q      <= cnt_d;
      key_len_q  <= key_len_d;
      kidx_q     <= kidx_d;
      key_err_q  <= key_err_d;
      ks_valid_q <= ks_valid_d;
      ks_data_q  <= ks_data_d;
      key_q      <= key_d;
    end
  end

  assign key_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign busy      = (state_q != ST_IDLE);
  assign ks_valid  = ks_valid_q;
  assign ks_data   = ks_data_q;
  assign key_err   = key_err_q;

endmodule
`default_nettype wire

// File: tb/tb_rc4_stream.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_rc4_stream                                             |
// | Description : Self-checking bench for rc4_stream against an RC4 model.  |
// | Revision    : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+
module tb_rc4_stream;
  import rc4_pkg::*;

`ifdef RC4_DROP_EN
  localparam int DROP = 4;
`else
  localparam int DROP = 0;
`endif
  localparam int KMAX = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       abort = 1'b0;
  logic       key_valid = 1'b0;
  logic [7:0] key_data = 8'h00;
  logic       key_last = 1'b0;
  logic       ks_ready = 1'b0;
  logic       key_ready, ks_valid, busy, key_err;
  logic [7:0] ks_data;

  rc4_stream #(.WORD_W(8), .KEY_MAX(KMAX), .DROP_N((DROP > 0) ? DROP : 768)) dut (
    .clk       (clk),
    .rst       (rst),
    .abort     (abort),
    .key_valid (key_valid),
    .key_data  (key_data),
    .key_last  (key_last),
    .key_ready (key_ready),
    .ks_valid  (ks_valid),
    .ks_data   (ks_data),
    .ks_ready  (ks_ready),
    .busy      (busy),
    .key_err   (key_err)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  byte unsigned key_buf[256];
  int           exp_ks[64];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Textbook RC4 (optionally discarding the first skip words).
  task automatic ref_rc4(input int klen, input int n, input int skip);
    int s[256];
    int i, j, t;
    for (int k = 0; k < 256; k++) s[k] = k;
    j = 0;
    for (int k = 0; k < 256; k++) begin
      j = (j + s[k] + int'(key_buf[k % klen])) % 256;
      t = s[k]; s[k] = s[j]; s[j] = t;
    end
    i = 0;
    j = 0;
    for (int k = 0; k < n + skip; k++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      if (k >= skip) exp_ks[k - skip] = s[(s[i] + s[j]) % 256];
    end
  endtask

  task automatic set_str(input string str);
    for (int k = 0; k < str.len(); k++) key_buf[k] = str[k];
  endtask

  task automatic send_key(input int len);
    for (int w = 0; w < len; w++) begin
      key_valid = 1'b1;
      key_data  = key_buf[w];
      key_last  = (w == len - 1);
      check("key_ready_load", 32'(key_ready), 32'd1);
      tick;
    end
    key_valid = 1'b0;
    key_last  = 1'b0;
  endtask

  task automatic wait_first(input int lat);
    int n;
    n = 0;
    while (!ks_valid && n < 5000) begin
      tick;
      n++;
    end
    check("first_latency", 32'(n), 32'(lat));
  endtask

  task automatic collect(input int n, input bit rnd, input bit noise);
    int         got, guard, last;
    bit         stalled;
    logic [7:0] held;
    got = 0; guard = 0; last = -1; stalled = 1'b0; held = 8'h00;
    while (got < n && guard < 3000) begin
      if (stalled) begin
        check("stall_valid", 32'(ks_valid), 32'd1);
        check("stall_data", 32'(ks_data), 32'(held));
      end
      ks_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (noise) begin
        key_valid = 1'($urandom_range(0, 1));
        key_data  = 8'($urandom);
        check("key_ready_busy", 32'(key_ready), 32'd0);
      end
      if (ks_valid && ks_ready) begin
        check("ks_word", 32'(ks_data), 32'(exp_ks[got]));
        if (!rnd && last >= 0) check("rate", 32'(cyc - last), 32'd3);
        last    = cyc;
        got++;
        stalled = 1'b0;
      end else begin
        stalled = ks_valid;
        held    = ks_data;
      end
      tick;
      guard++;
    end
    if (got < n) check("collect_timeout", 32'(got), 32'(n));
    key_valid = 1'b0;
    ks_ready  = 1'b0;
  endtask

  task automatic idle_checks(input string tag);
    check({tag, "_ks_valid"}, 32'(ks_valid), 32'd0);
    check({tag, "_key_ready"}, 32'(key_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic abort_pulse;
    check("busy_pre_abort", 32'(busy), 32'd1);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    idle_checks("abort");
  endtask

  initial begin
    byte unsigned key_lit[10];
    int           lat, n, lens[3];
    key_lit = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
    lat = first_ks_latency(8, DROP);

    // Reset values
    tick;
    tick;
    idle_checks("reset");
    check("reset_key_err", 32'(key_err), 32'd0);
    check("reset_ks_data", 32'(ks_data), 32'd0);
    rst = 1'b0;
    tick;

    // "Key" with continuous ks_ready
    set_str("Key");
    for (int k = 0; k < 10 - DROP; k++) exp_ks[k] = key_lit[k + DROP];
    send_key(3);
    wait_first(lat);
    collect(10 - DROP, 1'b0, 1'b0);
    abort_pulse();

    // "Secret" with random backpressure and ignored key traffic
    set_str("Secret");
    ref_rc4(6, 8, DROP);
    send_key(6);
    wait_first(lat);
    collect(8, 1'b1, 1'b1);

    // Abort coincident with an output handshake
    n = 0;
    while (!ks_valid && n < 10) begin
      tick;
      n++;
    end
    check("hold_valid", 32'(ks_valid), 32'd1);
    ks_ready = 1'b1;
    abort    = 1'b1;
    tick;
    abort    = 1'b0;
    ks_ready = 1'b0;
    idle_checks("abort_hs");

    // Over-long key: 20 words offered, only 16 used
    for (int k = 0; k < 20; k++) key_buf[k] = 8'($urandom);
    ref_rc4(KMAX, 12, DROP);
    send_key(20);
    check("key_err_set", 32'(key_err), 32'd1);
    wait_first(lat);
    collect(12, 1'b1, 1'b0);
    abort_pulse();
    check("key_err_sticky", 32'(key_err), 32'd1);

    // "Wiki": abort mid-KSA, then reload
    set_str("Wiki");
    send_key(4);
    check("key_err_clear", 32'(key_err), 32'd0);
    for (int k = 0; k < 400; k++) tick;
    abort_pulse();
    ref_rc4(4, 6, DROP);
    send_key(4);
    wait_first(lat);
    collect(6, 1'b0, 1'b0);

    // Async reset between clock edges while in PRGA_SW
    ks_ready = 1'b1;
    tick;
    ks_ready = 1'b0;
    check("busy_prga", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    idle_checks("async_rst");
    check("async_rst_ks_data", 32'(ks_data), 32'd0);
    check("async_rst_key_err", 32'(key_err), 32'd0);
    #1;
    rst = 1'b0;
    tick;
    set_str("Key");
    ref_rc4(3, 10, DROP);
    send_key(3);
    wait_first(lat);
    collect(10, 1'b1, 1'b0);
    abort_pulse();

    // Random keys at the length boundaries and in between
    lens = '{1, KMAX, int'($urandom_range(2, KMAX - 1))};
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < lens[r]; k++) key_buf[k] = 8'($urandom);
      ref_rc4(lens[r], 8, DROP);
      send_key(lens[r]);
      check("rand_key_err", 32'(key_err), 32'd0);
      wait_first(lat);
      collect(8, 1'b1, 1'b0);
      abort_pulse();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
